// File: rtl/hps_if_pkg.sv
// Shared register map and field positions for the HPS sample reader.
package hps_if_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_ID     = 2'd3;

  localparam logic [31:0] ID_VALUE = 32'h5352_0001;

  // STATUS fields
  localparam int unsigned STATUS_EMPTY_BIT    = 0;
  localparam int unsigned STATUS_FULL_BIT     = 1;
  localparam int unsigned STATUS_OVERFLOW_BIT = 2;
  localparam int unsigned STATUS_LEVEL_LSB    = 8;
  localparam int unsigned STATUS_DROP_LSB     = 16;
  localparam int unsigned STATUS_CLEAR_BIT    = 0;

  // CONTROL fields
  localparam int unsigned CTRL_IRQ_EN_BIT = 0;
  localparam int unsigned CTRL_THRESH_LSB = 8;

  // DATA word valid flag
  localparam int unsigned DATA_VALID_BIT = 31;

endpackage

// File: rtl/hps_sample_reader_if.sv
// Avalon-MM slave bus bundle for the HPS sample reader.
interface hps_sample_reader_if;

  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous FIFO; a push into a full FIFO is taken when a pop frees the slot in the same cycle.
module sample_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       count_q;
  logic              push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCount);
  assign level   = count_q;
  assign dout    = mem[rptr_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= din;
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + (AW + 1)'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/hps_sample_reader.sv
// Avalon-MM slave that buffers fabric samples for HPS readout with a fill-level interrupt.
module hps_sample_reader
  import hps_if_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [DATA_W-1:0]    sample_data,
  hps_sample_reader_if.slave   avs,
  output logic                 irq
);

  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [AW:0]       fifo_level;

  logic       rd_data, pop_acc, push_acc, drop, wr_en, clr, ctrl_wr;
  logic [7:0] level_next;
  logic       irq_en_q, irq_en_d, overflow_q, overflow_d, irq_d;
  logic [7:0] thresh_q, thresh_d, drop_cnt_q, drop_cnt_d;
  logic [31:0] rdata_d, readdata_q;
  logic       rdv_q;
  logic       unused_wdata;

  assign unused_wdata = ^{avs.writedata[31:16], avs.writedata[7:1]};

  assign rd_data  = avs.read && (avs.address == ADDR_DATA);
  assign pop_acc  = rd_data && !fifo_empty;
  assign push_acc = sample_valid && (!fifo_full || pop_acc);
  assign drop     = sample_valid && !push_acc;
  // A read in the same cycle wins; the write is discarded.
  assign wr_en    = avs.write && !avs.read;
  assign clr      = wr_en && (avs.address == ADDR_STATUS) && avs.writedata[STATUS_CLEAR_BIT];
  assign ctrl_wr  = wr_en && (avs.address == ADDR_CTRL);

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (sample_valid),
    .pop   (rd_data),
    .din   (sample_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Next-state for control/status registers and the interrupt.
  always_comb begin
    irq_en_d   = irq_en_q;
    thresh_d   = thresh_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (ctrl_wr) begin
      irq_en_d = avs.writedata[CTRL_IRQ_EN_BIT];
      thresh_d = avs.writedata[CTRL_THRESH_LSB +: 8];
      if (thresh_d == 8'd0) thresh_d = 8'd1;
    end
    // A drop in the same cycle as a clear leaves one recorded drop.
    if (drop) begin
      overflow_d = 1'b1;
      if (clr)                     drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hff) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
    level_next = 8'(fifo_level);
    if (push_acc && !pop_acc)      level_next = level_next + 8'd1;
    else if (pop_acc && !push_acc) level_next = level_next - 8'd1;
    irq_d = irq_en_d && ((level_next >= thresh_d) || overflow_d);
  end

  // Read data mux for the addressed register.
  always_comb begin
    rdata_d = '0;
    unique case (avs.address)
      ADDR_DATA: begin
        if (!fifo_empty) begin
          rdata_d[DATA_W-1:0]     = fifo_dout;
          rdata_d[DATA_VALID_BIT] = 1'b1;
        end
      end
      ADDR_STATUS: begin
        rdata_d[STATUS_EMPTY_BIT]          = fifo_empty;
        rdata_d[STATUS_FULL_BIT]           = fifo_full;
        rdata_d[STATUS_OVERFLOW_BIT]       = overflow_q;
        rdata_d[STATUS_LEVEL_LSB +: 8]     = 8'(fifo_level);
        rdata_d[STATUS_DROP_LSB +: 8]      = drop_cnt_q;
      end
      ADDR_CTRL: begin
        rdata_d[CTRL_IRQ_EN_BIT]           = irq_en_q;
        rdata_d[CTRL_THRESH_LSB +: 8]      = thresh_q;
      end
      default: rdata_d = ID_VALUE;
    endcase
  end

  // Register state, read response and interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en_q   <= 1'b0;
      thresh_q   <= 8'd1;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
      readdata_q <= '0;
      rdv_q      <= 1'b0;
      irq        <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      thresh_q   <= thresh_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      rdv_q      <= avs.read;
      irq        <= irq_d;
      if (avs.read) readdata_q <= rdata_d;
    end
  end

  assign avs.readdata      = readdata_q;
  assign avs.readdatavalid = rdv_q;
  assign avs.waitrequest   = 1'b0;

endmodule

// File: tb/tb_hps_sample_reader.sv
// Scoreboard bench: reads push expected words, a negedge monitor checks each read response.
module tb_hps_sample_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic        irq;
  logic        rd_prev = 1'b0;

  int unsigned tests = 0;
  int unsigned errors = 0;
  logic [31:0] exp_q[$];

  hps_sample_reader_if bus ();

  hps_sample_reader #(
    .DATA_W (16),
    .DEPTH  (16),
    .AW     (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .avs          (bus),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // Expected readdatavalid: a read strobe seen at the previous edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) rd_prev <= 1'b0;
    else        rd_prev <= bus.read;
  end

  // Monitor: check response timing and pop/compare read data.
  always @(negedge clk) begin
    if (bus.readdatavalid || rd_prev) begin
      tests++;
      if (bus.readdatavalid !== rd_prev) begin
        errors++;
        $display("FAIL rdv_timing: got %b want %b at %0t", bus.readdatavalid, rd_prev, $time);
      end
    end
    if (bus.readdatavalid) begin
      tests++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got %h want none", bus.readdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.readdata !== e) begin
          errors++;
          $display("FAIL readdata: got %h want %h at %0t", bus.readdata, e, $time);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [1:0] addr, input logic [31:0] exp);
    bus.address = addr;
    bus.read = 1'b1;
    exp_q.push_back(exp);
    cycle();
    bus.read = 1'b0;
  endtask

  task automatic write_reg(input logic [1:0] addr, input logic [31:0] data);
    bus.address = addr;
    bus.writedata = data;
    bus.write = 1'b1;
    cycle();
    bus.write = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    sample_valid = 1'b1;
    sample_data = d;
    cycle();
    sample_valid = 1'b0;
  endtask

  initial begin
    bus.address = '0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.writedata = '0;
    repeat (3) cycle();
    reset = 1'b1;
    cycle();

    // Reset state
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_rdv", {31'b0, bus.readdatavalid}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("waitrequest", {31'b0, bus.waitrequest}, 32'h0);

    // ID and STATUS, readdata holds afterwards
    read_reg(2'd3, 32'h5352_0001);
    read_reg(2'd1, 32'h0000_0001);
    repeat (3) cycle();
    check("readdata_hold", bus.readdata, 32'h0000_0001);
    check("irq_idle", {31'b0, irq}, 32'h0);

    // FIFO order and empty read
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    read_reg(2'd0, 32'h8000_1111);
    read_reg(2'd0, 32'h8000_2222);
    read_reg(2'd0, 32'h8000_3333);
    read_reg(2'd0, 32'h0000_0000);
    read_reg(2'd1, 32'h0000_0001);

    // Threshold interrupt
    write_reg(2'd2, 32'h0000_0401);
    read_reg(2'd2, 32'h0000_0401);
    for (int i = 0; i < 4; i++) begin
      push(16'h00a0 + 16'(i));
      check($sformatf("irq_after_push%0d", i), {31'b0, irq}, {31'b0, i == 3});
    end
    read_reg(2'd0, 32'h8000_00a0);
    check("irq_after_pop", {31'b0, irq}, 32'h0);

    // Fill to full then overflow with three drops
    for (int i = 0; i < 13; i++) push(16'h0100 + 16'(i));
    for (int i = 0; i < 3; i++) push(16'hdead);
    read_reg(2'd1, 32'h0003_1006);
    check("irq_full", {31'b0, irq}, 32'h1);
    write_reg(2'd1, 32'h0000_0001);
    read_reg(2'd1, 32'h0000_1002);

    // Push and pop together while full: no drop, oldest returned
    sample_valid = 1'b1;
    sample_data = 16'hbeef;
    read_reg(2'd0, 32'h8000_00a1);
    sample_valid = 1'b0;
    read_reg(2'd1, 32'h0000_1002);
    read_reg(2'd0, 32'h8000_00a2);
    read_reg(2'd0, 32'h8000_00a3);
    for (int i = 0; i < 13; i++) read_reg(2'd0, 32'h8000_0100 + 32'(i));
    read_reg(2'd0, 32'h8000_beef);
    read_reg(2'd1, 32'h0000_0001);
    check("irq_drained", {31'b0, irq}, 32'h0);

    // Read and write together: write ignored; threshold 0 stored as 1
    bus.write = 1'b1;
    bus.writedata = 32'h0;
    read_reg(2'd2, 32'h0000_0401);
    bus.write = 1'b0;
    read_reg(2'd2, 32'h0000_0401);
    write_reg(2'd2, 32'h0000_0001);
    read_reg(2'd2, 32'h0000_0101);
    write_reg(2'd2, 32'h0000_0401);

    // Reset with a read in flight
    for (int i = 0; i < 5; i++) push(16'h0050 + 16'(i));
    check("irq_level5", {31'b0, irq}, 32'h1);
    bus.address = 2'd0;
    bus.read = 1'b1;
    cycle();
    bus.read = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_mid_rdv", {31'b0, bus.readdatavalid}, 32'h0);
    check("rst_mid_irq", {31'b0, irq}, 32'h0);
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    read_reg(2'd1, 32'h0000_0001);
    read_reg(2'd2, 32'h0000_0100);

    repeat (4) cycle();
    check("pending_responses", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/hps_sample_reader.md
Name: hps_sample_reader

Overview:
- Avalon-MM slave that carries data from FPGA to HPS, the return path for the HPS-written range control.
- Captures fabric sensor/feedback samples into a small FIFO and lets HPS software drain them by register reads.
- Raises a level-based interrupt when the FIFO reaches a programmable fill threshold.
- Sits on the lightweight HPS-to-FPGA bridge beside the range-control slave.

Parameters:
- DATA_W, 16, sample width in bits (1..31).
- DEPTH, 16, FIFO depth in entries; power of two, 2..128.
- AW, 4, log2(DEPTH); must be consistent with DEPTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- sample_valid  in  1  qualifies sample_data for one cycle.
- sample_data  in  DATA_W  sample from the fabric.
- address  in  2  Avalon word address.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, registered.
- readdatavalid  out  1  high exactly one cycle after an accepted read.
- waitrequest  out  1  tied 0; every access is accepted in one cycle.
- irq  out  1  level interrupt to HPS, registered.

Behaviour:
- Reset values:
  - readdata 0, readdatavalid 0, irq 0.
  - FIFO empty, irq_en 0, threshold 1, overflow 0, drop_cnt 0.
- Register map (address):
  - 0 DATA (RO): read pops one entry. readdata = {1'b1, zeros, sample}, with bit31 as the valid flag. If the FIFO is empty, readdata = 0 and there is no pop.
  - 1 STATUS (R/W1C): read returns [0] empty, [1] full, [2] overflow, [15:8] level, [23:16] drop_cnt, others 0. Writing writedata[0]=1 clears overflow and drop_cnt.
  - 2 CONTROL (R/W): [0] irq_en, [15:8] threshold; reads back the same fields. A written threshold of 0 is stored as 1.
  - 3 ID (RO): constant 32'h5352_0001; writes ignored.
- Read latency:
  - Fixed at 1: readdata and readdatavalid are registered on the cycle after read=1.
  - readdatavalid is 0 in all other cycles.
  - readdata holds its last value between reads.
- Read and write in the same cycle: the read is performed and the write is ignored.
- Push:
  - sample_valid=1 and not full → write entry, level+1.
  - sample_valid=1 and full → sample dropped, overflow set (sticky), drop_cnt+1, saturating at 255.
- Simultaneous push and DATA pop:
  - When full, the pop frees the slot in the same cycle, so the push is accepted: no drop, level unchanged.
  - When empty, the pop is a no-op (returns 0) and the push is accepted: level 1.
  - Otherwise level is unchanged and FIFO order is preserved.
- Overflow clear vs. new drop in the same cycle: the drop wins. overflow=1 and drop_cnt=1.
- Pointers: AW-bit, wrap modulo DEPTH. level is AW+1 bits, zero-extended into STATUS[15:8].
- IRQ:
  - irq is registered as irq_en && (level_next >= threshold), where level_next is the FIFO level after this cycle's push/pop.
  - Therefore irq updates one cycle after the push or pop.
  - A threshold above DEPTH never fires except via overflow; irq is also asserted when irq_en && overflow.
  - Clearing irq_en deasserts irq on the next cycle.
- Reset mid-operation: FIFO contents are discarded, pointers zeroed, and any pending readdatavalid is dropped immediately.

Decomposition:
- Shared package (hps_if_pkg): register address constants (ADDR_DATA, ADDR_STATUS, ADDR_CTRL, ADDR_ID), ID constant, STATUS/CONTROL bit-position constants.
- Sub-module: sample_fifo, a synchronous FIFO.
  - Ports: push, pop, din, dout, full, empty, level.
  - Pop is honoured only when not empty; push is honoured when not full, or when full with a simultaneous pop.
- Top level owns the Avalon decode, control/status registers, drop counter and irq.

Test Plan:
- After reset release, read ID and STATUS → readdatavalid one cycle later. readdata 32'h5352_0001, then 32'h0000_0001 (empty); irq 0.
- Push 3 samples 0x1111, 0x2222, 0x3333; read DATA ×4 → 0x8000_1111, 0x8000_2222, 0x8000_3333, then 0x0000_0000; STATUS level 0.
- CONTROL write 0x0000_0401 (threshold 4, irq_en 1); push 4 samples → irq rises the cycle after the 4th push. One DATA read → irq falls the cycle after the read.
- Fill to 16, push 3 more → STATUS = full|overflow, level 16, drop_cnt 3 (0x0003_1006). Write STATUS 0x1 → 0x0000_1002.
- Full FIFO with push and DATA read in the same cycle → no overflow, level stays 16. Returned data is the oldest entry; the new sample is read last.
- Assert reset (0) while at level 5 with a read in flight → readdatavalid 0 and irq 0 immediately. After release: STATUS 0x0000_0001, CONTROL 0x0000_0100.
